// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared FSM state encoding and output polarity helper
// for the scan_decoder block and its one-hot decoder.
// Ports: none (package).
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_e;

   // Map a logical "active" bit onto the pin level for the chosen polarity.
   function automatic logic drive_level(input logic active, input logic active_low);
      return active ^ active_low;
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: combinational select-to-one-hot decoder with bit order and
// polarity options; all bits inactive when valid is low.
// Ports: sel (channel index), valid (drive enable), onehot (2**SEL_W pin levels).
module onehot_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter int MSB_FIRST  = 1,
   parameter int ACTIVE_LOW = 0
) (
   input  logic [SEL_W-1:0]    sel,
   input  logic                valid,
   output logic [2**SEL_W-1:0] onehot
);

   localparam int N = 2**SEL_W;

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         // Bit i belongs to channel N-1-i when the scan runs MSB first.
         onehot[i] = drive_level(valid && (sel == SEL_W'((MSB_FIRST != 0) ? (N - 1 - i) : i)),
                                 ACTIVE_LOW != 0);
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot channel driver with auto scan (slot = blank
// dead-time + drive) and manual host-selected mode with blanking on change.
// Ports: clk, rst (async, active high), en, mode (1 auto / 0 manual), load +
// sel_in (manual select), out (one-hot drive), cur_sel, slot_start, wrap.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W      = 3,
   parameter int N_CH       = 8,
   parameter int DIV        = 50000,
   parameter int BLANK      = 4,
   parameter int ACTIVE_LOW = 0,
   parameter int MSB_FIRST  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                mode,
   input  logic                load,
   input  logic [SEL_W-1:0]    sel_in,
   output logic [2**SEL_W-1:0] out,
   output logic [SEL_W-1:0]    cur_sel,
   output logic                slot_start,
   output logic                wrap
);

   localparam int                N          = 2**SEL_W;
   localparam int                CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'((BLANK > 0) ? (BLANK - 1) : 0);
   localparam logic [CNT_W-1:0]  DRIVE_LAST = CNT_W'(DIV - BLANK - 1);
   localparam logic [SEL_W-1:0]  LAST_CH    = SEL_W'(N_CH - 1);
   localparam state_e            SLOT_ENTRY = (BLANK > 0) ? ST_BLANK : ST_DRIVE;
   localparam logic [N-1:0]      OUT_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

   if (N_CH < 1 || N_CH > N || DIV < 2 || BLANK < 0 || DIV <= BLANK) begin : g_param_err
      $error("scan_decoder: illegal parameter combination");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N-1:0]     out_q, out_d;
   logic             start_q, start_d;
   logic             wrap_q, wrap_d;
   logic             mode_q;
   logic             load_ok, slot_end, restart;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      start_d = 1'b0;
      wrap_d  = 1'b0;
      restart = 1'b0;

      load_ok  = !mode && load && (int'(sel_in) < N_CH) && (sel_in != sel_q);
      // Only a slot that ran entirely in auto mode advances; a mode flip restarts instead.
      slot_end = (state_q == ST_DRIVE) && mode && mode_q && (cnt_q == DRIVE_LAST);

      // Channel updates happen even when en drops on the same edge.
      if (load_ok) begin
         sel_d = sel_in;
      end
      if (slot_end) begin
         if (sel_q == LAST_CH) begin
            sel_d  = '0;
            wrap_d = 1'b1;
         end else begin
            sel_d = sel_q + 1'b1;
         end
      end

      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (state_q == ST_IDLE || load_ok || slot_end || (mode != mode_q)) begin
         restart = 1'b1;
      end else begin
         case (state_q)
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_DRIVE;
                  cnt_d   = '0;
                  start_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_DRIVE: begin
               // Manual mode parks here with the counter frozen.
               if (mode) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      if (restart) begin
         state_d = SLOT_ENTRY;
         cnt_d   = '0;
         start_d = (BLANK == 0);
      end
   end

   // Decode the next-state view so out lands on the same edge as the state.
   onehot_decoder #(
      .SEL_W      (SEL_W),
      .MSB_FIRST  (MSB_FIRST),
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_dec (
      .sel    (sel_d),
      .valid  (state_d == ST_DRIVE),
      .onehot (out_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         out_q   <= OUT_OFF;
         start_q <= 1'b0;
         wrap_q  <= 1'b0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
         start_q <= start_d;
         wrap_q  <= wrap_d;
         mode_q  <= mode;
      end
   end

   assign out        = out_q;
   assign cur_sel    = sel_q;
   assign slot_start = start_q;
   assign wrap       = wrap_q;

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered one-hot channel decoder with a built-in scan sequencer. It drives multiplexed display digits, LED columns or chip-selects on the board. In auto mode it steps through `N_CH` channels with a programmable slot length and dead-time blanking. In manual mode it holds a host-loaded channel and inserts blanking on every change. It sits between the display/IO controllers and the pin-level drivers.

## Interface
- `SEL_W`, 3: select width; output width `N = 2**SEL_W`.
- `N_CH`, 8: channels actually used, 1..N; the scan wraps after `N_CH-1`.
- `DIV`, 50000: clock cycles per scan slot (blank + drive); must be ≥ 2 and > `BLANK`.
- `BLANK`, 4: dead-time cycles at the start of each slot; 0 disables blanking.
- `ACTIVE_LOW`, 0: 1 inverts `out` (active = 0, inactive = all ones).
- `MSB_FIRST`, 1: 1 means channel k drives `out[N-1-k]`; 0 means channel k drives `out[k]`.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global enable.
- `mode` in 1: 1 = auto-scan, 0 = manual.
- `load` in 1: manual-mode select strobe, one cycle.
- `sel_in` in `SEL_W`: manual channel, sampled on `load`.
- `out` out `N`: registered one-hot channel drive.
- `cur_sel` out `SEL_W`: channel currently selected.
- `slot_start` out 1: one-cycle pulse on the first DRIVE cycle of a slot.
- `wrap` out 1: one-cycle pulse when the auto scan steps from `N_CH-1` to 0.

## Operation
- States: IDLE, BLANK, DRIVE.
- Slot counter is `$clog2(DIV)` bits wide and clears on every state entry.
- Reset (asynchronous, immediate, no clock edge needed) sets: state IDLE, `cur_sel`=0, counter 0, `slot_start`=`wrap`=0, `out` inactive (0s, or 1s when `ACTIVE_LOW`).
- IDLE:
  - `out` is inactive.
  - `en`=1 moves to BLANK, or directly to DRIVE when `BLANK`=0.
- BLANK:
  - `out` is inactive.
  - After `BLANK` cycles, moves to DRIVE.
- DRIVE:
  - `out` drives `cur_sel`; `slot_start` pulses on the first DRIVE cycle.
  - Auto mode: after `DIV-BLANK` cycles, `cur_sel` becomes `(cur_sel==N_CH-1) ? 0 : cur_sel+1`. `wrap` pulses in the same cycle `cur_sel` becomes 0. The state then returns to BLANK.
  - Manual mode: DRIVE holds indefinitely and the counter is frozen.
- Manual `load`:
  - `sel_in` < `N_CH` and ≠ `cur_sel`: `cur_sel`←`sel_in`, then go to BLANK (DRIVE when `BLANK`=0).
  - `sel_in` = `cur_sel`: no effect.
  - `sel_in` ≥ `N_CH`: ignored.
  - `load` is honoured in IDLE as a preload and takes effect on the next enable.
- `load` is ignored in auto mode.
- A `mode` change while `en`=1 keeps `cur_sel` and restarts the slot: BLANK with the counter cleared.
- `en`=0 in any state moves to IDLE on the next edge. `cur_sel` is held and the next enable resumes from it.
- Simultaneous events:
  - `en` falling with `load` in manual mode: go to IDLE and still update `cur_sel`.
  - `en` falling at the auto slot end: go to IDLE and still advance `cur_sel`/`wrap`.

## Timing
- All outputs are registered and update on the same edge as the state.
- No combinational path from inputs to outputs.
- Enable-to-first-drive latency: `BLANK`+1 cycles after the edge sampling `en`=1.
- Auto-scan period: `N_CH`×`DIV` cycles.
- Per slot: `BLANK` cycles inactive, then `DIV-BLANK` cycles active.
- Manual `load`-to-drive: `BLANK`+1 cycles. `out` is inactive for exactly `BLANK` cycles between the two channels, and never has two active bits.
- Disable-to-inactive: 1 cycle.

## Structure
- Shared package `scan_decoder_pkg`: state encoding constants (IDLE=2'd0, BLANK=2'd1, DRIVE=2'd2) and a polarity helper function.
- One combinational sub-module, `onehot_decoder` (params `SEL_W`, `MSB_FIRST`, `ACTIVE_LOW`; inputs sel, valid; output one-hot). Its output is registered in `scan_decoder`.
- Parameter legality (`N_CH` ≤ `2**SEL_W`, `DIV` > `BLANK`) is checked at elaboration.

## Test plan
Defaults for all scenarios: `SEL_W`=3, `DIV`=8, `BLANK`=2, `MSB_FIRST`=1.

- **Reset:** `rst` pulse → `out`=8'h00, `cur_sel`=0, no pulses. With `ACTIVE_LOW`=1 → `out`=8'hFF.
- **Auto scan:** `en`=1, `mode`=1 → 2 cycles of 8'h00, then 8'b10000000 for 6 cycles with `slot_start` on the first. The next slot drives 8'b01000000. `wrap` pulses every 64 cycles.
- **Early wrap:** `N_CH`=5 → channels 0..4 only, then `cur_sel`=0 with `wrap`. Period is 40 cycles; `out[2:0]` is never active.
- **Manual select:** `mode`=0, `load` with `sel_in`=3 → 2 blank cycles, then 8'b00010000 held for over 100 cycles. `load` 3 again → no blank. `load` 6 with `N_CH`=5 → ignored.
- **Disable mid-drive:** drop `en` during DRIVE → `out`=0 on the next cycle. Re-enable resumes the same `cur_sel` after 2 blank cycles.
- **Asynchronous reset mid-slot:** assert `rst` between edges during DRIVE → `out` goes inactive immediately. After release, the scan restarts at channel 0 with blanking.
